// File: rtl/dhcp_client_hls_deadlock_detector.sv
// Watches per-process block/idle flags and declares deadlock after THRESH consecutive stuck cycles.
// It then reports each active blocked process once. Entries are held stable under rpt_ready backpressure.
module dhcp_client_hls_deadlock_detector #(
  parameter int NUM_PROC = 4,
  parameter int THRESH   = 16,
  parameter int CNT_W    = 16,
  localparam int IDX_W   = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_PROC-1:0] proc_block,
  input  logic [NUM_PROC-1:0] proc_idle,
  input  logic                clear,
  output logic                deadlock,
  output logic [NUM_PROC-1:0] block_snapshot,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [IDX_W-1:0]    rpt_idx,
  output logic [CNT_W-1:0]    stall_cnt
);

  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    ARMED   = 2'd1,
    REPORT  = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_inc;
  logic [NUM_PROC-1:0] mask;
  logic [NUM_PROC-1:0] low_bit;
  logic [NUM_PROC-1:0] mask_rest;
  logic                stuck;

  // Every process is either blocked or idle, but not all of them idle.
  assign stuck     = (&(proc_block | proc_idle)) && !(&proc_idle);
  assign cnt_inc   = cnt + 1'b1;
  assign low_bit   = mask & (~mask + 1'b1);
  assign mask_rest = mask & ~low_bit;
  assign stall_cnt = cnt;

  always_comb begin
    rpt_idx = '0;
    for (int i = NUM_PROC - 1; i >= 0; i--) begin
      if (mask[i]) rpt_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= MONITOR;
      cnt            <= '0;
      mask           <= '0;
      deadlock       <= 1'b0;
      block_snapshot <= '0;
      rpt_valid      <= 1'b0;
    end else if (clear) begin
      state          <= MONITOR;
      cnt            <= '0;
      mask           <= '0;
      deadlock       <= 1'b0;
      block_snapshot <= '0;
      rpt_valid      <= 1'b0;
    end else begin
      case (state)
        MONITOR: begin
          if (stuck) begin
            state <= ARMED;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        ARMED: begin
          if (!stuck) begin
            state <= MONITOR;
            cnt   <= '0;
          end else if (cnt_inc == CNT_W'(THRESH)) begin
            state          <= REPORT;
            cnt            <= CNT_W'(THRESH);
            deadlock       <= 1'b1;
            block_snapshot <= proc_block;
            mask           <= proc_block & ~proc_idle;
            rpt_valid      <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        REPORT: begin
          // Counter and process inputs are frozen until clear.
          if (rpt_ready) begin
            mask <= mask_rest;
            if (mask_rest == '0) begin
              state     <= HOLD;
              rpt_valid <= 1'b0;
            end
          end
        end
        default: begin
          state <= HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dhcp_client_hls_deadlock_detector.sv
// Directed bench for the deadlock detector with NUM_PROC=4, THRESH=8.
module tb_dhcp_client_hls_deadlock_detector;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] proc_block;
  logic [3:0] proc_idle;
  logic       clear;
  logic       deadlock;
  logic [3:0] block_snapshot;
  logic       rpt_valid;
  logic       rpt_ready;
  logic [1:0] rpt_idx;
  logic [15:0] stall_cnt;

  int n_pass = 0;
  int n_total = 0;

  dhcp_client_hls_deadlock_detector #(
    .NUM_PROC(4),
    .THRESH  (8),
    .CNT_W   (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .proc_block    (proc_block),
    .proc_idle     (proc_idle),
    .clear         (clear),
    .deadlock      (deadlock),
    .block_snapshot(block_snapshot),
    .rpt_valid     (rpt_valid),
    .rpt_ready     (rpt_ready),
    .rpt_idx       (rpt_idx),
    .stall_cnt     (stall_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_deadlock"}, 32'(deadlock), 32'd0);
    chk({tag, "_snapshot"}, 32'(block_snapshot), 32'd0);
    chk({tag, "_rpt_valid"}, 32'(rpt_valid), 32'd0);
    chk({tag, "_rpt_idx"}, 32'(rpt_idx), 32'd0);
    chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    clear      = 1'b0;
    rpt_ready  = 1'b0;
    proc_block = 4'b0000;
    proc_idle  = 4'b0000;
    step(2);
    reset = 1'b0;
    chk_idle_outputs("reset");

    // Basic declaration: idle 0011, block 1100 held.
    proc_idle  = 4'b0011;
    proc_block = 4'b1100;
    step(1);
    chk("armed_cnt1", 32'(stall_cnt), 32'd1);
    step(6);
    chk("pre_thresh_cnt", 32'(stall_cnt), 32'd7);
    chk("pre_thresh_deadlock", 32'(deadlock), 32'd0);
    step(1);
    chk("decl_deadlock", 32'(deadlock), 32'd1);
    chk("decl_snapshot", 32'(block_snapshot), 32'hC);
    chk("decl_stall_cnt", 32'(stall_cnt), 32'd8);
    chk("decl_rpt_valid", 32'(rpt_valid), 32'd1);
    chk("decl_rpt_idx", 32'(rpt_idx), 32'd2);

    // Backpressure: entry stable, inputs ignored.
    for (int i = 0; i < 5; i++) begin
      proc_block = (i % 2 == 0) ? 4'b0000 : 4'b1111;
      step(1);
      chk("bp_rpt_valid", 32'(rpt_valid), 32'd1);
      chk("bp_rpt_idx", 32'(rpt_idx), 32'd2);
      chk("bp_stall_cnt", 32'(stall_cnt), 32'd8);
    end
    chk("bp_snapshot", 32'(block_snapshot), 32'hC);

    rpt_ready = 1'b1;
    step(1);
    chk("rpt2_valid", 32'(rpt_valid), 32'd1);
    chk("rpt2_idx", 32'(rpt_idx), 32'd3);
    step(1);
    chk("hold_valid", 32'(rpt_valid), 32'd0);
    chk("hold_deadlock", 32'(deadlock), 32'd1);
    proc_idle  = 4'b1111;
    proc_block = 4'b0000;
    step(3);
    chk("hold_deadlock_late", 32'(deadlock), 32'd1);
    chk("hold_snapshot_late", 32'(block_snapshot), 32'hC);
    chk("hold_stall_cnt", 32'(stall_cnt), 32'd8);

    // Clear in HOLD, then re-declare with a fresh run.
    proc_idle  = 4'b0011;
    proc_block = 4'b1100;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk_idle_outputs("clear_hold");
    step(7);
    chk("redecl_pre_deadlock", 32'(deadlock), 32'd0);
    chk("redecl_pre_cnt", 32'(stall_cnt), 32'd7);
    step(1);
    chk("redecl_deadlock", 32'(deadlock), 32'd1);
    chk("redecl_valid", 32'(rpt_valid), 32'd1);

    // Reset in the middle of REPORT discards pending entries.
    rpt_ready = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    proc_block = 4'b0000;
    chk_idle_outputs("reset_mid_report");

    // 7 stuck, 1 break, 7 stuck: never declares.
    proc_idle  = 4'b0011;
    proc_block = 4'b1100;
    step(7);
    chk("run1_cnt", 32'(stall_cnt), 32'd7);
    proc_block = 4'b0000;
    step(1);
    chk("break_cnt", 32'(stall_cnt), 32'd0);
    proc_block = 4'b1100;
    step(7);
    chk("run2_cnt", 32'(stall_cnt), 32'd7);
    chk("run2_deadlock", 32'(deadlock), 32'd0);

    // Clear wins over a coincident declaration.
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clear_vs_decl_deadlock", 32'(deadlock), 32'd0);
    chk("clear_vs_decl_cnt", 32'(stall_cnt), 32'd0);

    // All idle is never stuck.
    proc_idle  = 4'b1111;
    proc_block = 4'b1010;
    step(10);
    chk("all_idle_cnt", 32'(stall_cnt), 32'd0);
    chk("all_idle_deadlock", 32'(deadlock), 32'd0);

    // Mask excludes idle processes; continuous ready gives one entry per cycle.
    proc_idle  = 4'b0101;
    proc_block = 4'b1111;
    rpt_ready  = 1'b1;
    step(8);
    chk("mask_decl_deadlock", 32'(deadlock), 32'd1);
    chk("mask_decl_snapshot", 32'(block_snapshot), 32'hF);
    chk("mask_idx_first", 32'(rpt_idx), 32'd1);
    step(1);
    chk("mask_idx_second", 32'(rpt_idx), 32'd3);
    chk("mask_valid_second", 32'(rpt_valid), 32'd1);
    step(1);
    chk("mask_hold_valid", 32'(rpt_valid), 32'd0);
    chk("mask_hold_deadlock", 32'(deadlock), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dhcp_client_hls_deadlock_detector.md
DHCP_CLIENT_HLS_DEADLOCK_DETECTOR -- requirements
Module: dhcp_client_hls_deadlock_detector

Interface
REQ-001 Parameter NUM_PROC, default 4: number of per-process deadlock monitors aggregated.
REQ-002 Parameter THRESH, default 16, legal range 2..2^CNT_W-1: number of consecutive stuck cycles required to declare deadlock.
REQ-003 Parameter CNT_W, default 16: width of the stuck counter.
REQ-004 Derived IDX_W SHALL equal max(1, clog2(NUM_PROC)).
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 proc_block  input  NUM_PROC  bit i = block output of the monitor for process i.
REQ-008 proc_idle  input  NUM_PROC  bit i = process i idle (ap_idle).
REQ-009 clear  input  1  one-cycle pulse that releases a latched deadlock.
REQ-010 deadlock  output  1  registered deadlock-declared flag.
REQ-011 block_snapshot  output  NUM_PROC  proc_block value latched at the moment of declaration.
REQ-012 rpt_valid  output  1  report entry valid.
REQ-013 rpt_ready  input  1  report consumer ready.
REQ-014 rpt_idx  output  IDX_W  index of the blocked process being reported.
REQ-015 stall_cnt  output  CNT_W  current count of consecutive stuck cycles.

Function
REQ-016 stuck SHALL be true when (proc_block | proc_idle) is all-ones and proc_idle is not all-ones; it is combinational from the inputs sampled each cycle.
REQ-017 The FSM SHALL have four states: MONITOR, ARMED, REPORT and HOLD.
REQ-018 MONITOR: cnt=0; if stuck, go to ARMED with cnt<=1; otherwise stay in MONITOR.
REQ-019 ARMED: if !stuck, go to MONITOR with cnt<=0.
REQ-020 ARMED: if stuck and cnt+1<THRESH, set cnt<=cnt+1.
REQ-021 ARMED: if stuck and cnt+1==THRESH, go to REPORT with cnt<=THRESH, deadlock<=1, block_snapshot<=proc_block and mask<=proc_block&~proc_idle.
REQ-022 As a result of REQ-018..021, deadlock SHALL rise at the edge on which the THRESH-th consecutive stuck cycle is sampled, so deadlock is visible the cycle after that sample.
REQ-023 A single non-stuck cycle anywhere in the run SHALL restart the count from zero.
REQ-024 REPORT: rpt_valid=1 and rpt_idx = index of the lowest set bit of mask.
REQ-025 REPORT handshake: on rpt_valid&rpt_ready, clear that bit of mask; if it was the last set bit, go to HOLD, else stay in REPORT.
REQ-026 rpt_idx and rpt_valid SHALL remain stable while rpt_valid=1 and rpt_ready=0.
REQ-027 rpt_ready may be held high continuously, giving one entry per cycle.
REQ-028 HOLD: rpt_valid=0; deadlock and block_snapshot SHALL hold; input changes SHALL be ignored.
REQ-029 In REPORT and HOLD, cnt SHALL be frozen and proc_block/proc_idle SHALL be ignored.
REQ-030 clear=1 in any state SHALL force the next state to MONITOR with deadlock<=0, block_snapshot<=0, mask<=0, cnt<=0 and rpt_valid low the next cycle.
REQ-031 clear SHALL take priority over a coincident declaration or handshake.
REQ-032 clear while in MONITOR or ARMED SHALL also zero cnt.
REQ-033 mask SHALL never be empty on entry to REPORT, because stuck implies at least one active blocked process.
REQ-034 stall_cnt SHALL equal cnt; cnt SHALL never exceed THRESH.
REQ-035 deadlock, block_snapshot and rpt_valid SHALL be registered outputs.
REQ-036 rpt_idx SHALL be derived from the registered mask only.

Reset
REQ-037 On reset: state=MONITOR; deadlock=0, block_snapshot=0, rpt_valid=0, rpt_idx=0, stall_cnt=0, mask=0.
REQ-038 reset SHALL take priority over clear and over all other inputs, including mid-REPORT, where any pending report entries are discarded.

Verification (NUM_PROC=4, THRESH=8)
REQ-039 proc_idle=4'b0011, proc_block=4'b1100 held for 8 cycles -> deadlock=1 the cycle after the 8th sample, block_snapshot=4'b1100, stall_cnt=8.
REQ-040 Continue from REQ-039 with rpt_ready=1 -> rpt_idx=2 then 3 on consecutive cycles, then rpt_valid=0 (HOLD) and deadlock stays 1.
REQ-041 Stuck for 7 cycles, one non-stuck cycle, then stuck for 7 cycles -> deadlock never rises; stall_cnt returns to 0 at the break.
REQ-042 In REPORT with rpt_ready=0 for 5 cycles -> rpt_valid=1 and rpt_idx unchanged throughout; toggling proc_block has no effect.
REQ-043 clear pulsed in HOLD -> next cycle deadlock=0, block_snapshot=0, state MONITOR; a fresh 8-cycle stuck run re-declares deadlock.
REQ-044 All processes idle (proc_idle=4'b1111) with any proc_block -> never stuck, stall_cnt=0; reset asserted mid-REPORT -> all outputs 0 the next cycle.
